// File: rtl/fs_vmon_deglitch_if.sv
// Voltage-monitor fault bundle between the raw comparators, the deglitch stage and the safety core.
// Optional sticky status signals are present when FS_VMON_STICKY_EN is defined.
interface fs_vmon_deglitch_if;
    logic       fs_enable;
    logic [3:0] vmon_en;
    logic       vcoremon_ov_raw;
    logic       vcoremon_uv_raw;
    logic       vddio_ov_raw;
    logic       vddio_uv_raw;
    logic [3:0] vmonx_ov_raw;
    logic [3:0] vmonx_uv_raw;
    logic       vcoremon_ov;
    logic       vcoremon_uv;
    logic       vddio_ov;
    logic       vddio_uv;
    logic [3:0] vmonx_ov;
    logic [3:0] vmonx_uv;
    logic       blank_active;
    logic       vmon_fault_any;
`ifdef FS_VMON_STICKY_EN
    logic [11:0] sticky_clr;
    logic [11:0] sticky_sts;

    modport master (
        output fs_enable, vmon_en, vcoremon_ov_raw, vcoremon_uv_raw, vddio_ov_raw,
               vddio_uv_raw, vmonx_ov_raw, vmonx_uv_raw, sticky_clr,
        input  vcoremon_ov, vcoremon_uv, vddio_ov, vddio_uv, vmonx_ov, vmonx_uv,
               blank_active, vmon_fault_any, sticky_sts
    );
    modport slave (
        input  fs_enable, vmon_en, vcoremon_ov_raw, vcoremon_uv_raw, vddio_ov_raw,
               vddio_uv_raw, vmonx_ov_raw, vmonx_uv_raw, sticky_clr,
        output vcoremon_ov, vcoremon_uv, vddio_ov, vddio_uv, vmonx_ov, vmonx_uv,
               blank_active, vmon_fault_any, sticky_sts
    );
`else
    modport master (
        output fs_enable, vmon_en, vcoremon_ov_raw, vcoremon_uv_raw, vddio_ov_raw,
               vddio_uv_raw, vmonx_ov_raw, vmonx_uv_raw,
        input  vcoremon_ov, vcoremon_uv, vddio_ov, vddio_uv, vmonx_ov, vmonx_uv,
               blank_active, vmon_fault_any
    );
    modport slave (
        input  fs_enable, vmon_en, vcoremon_ov_raw, vcoremon_uv_raw, vddio_ov_raw,
               vddio_uv_raw, vmonx_ov_raw, vmonx_uv_raw,
        output vcoremon_ov, vcoremon_uv, vddio_ov, vddio_uv, vmonx_ov, vmonx_uv,
               blank_active, vmon_fault_any
    );
`endif
endinterface

// File: rtl/fs_vmon_deglitch.sv
// Synchronizes and debounces the 12 voltage-monitor comparator outputs, with per-channel
// enables and a post-enable blanking window. FS_VMON_STICKY_EN adds sticky fault status.
module fs_vmon_deglitch #(
    parameter int UDLY      = 1,
    parameter int FILT_CYC  = 16,
    parameter int BLANK_CYC = 32
) (
    input logic              clk,
    input logic              rst_n,
    fs_vmon_deglitch_if.slave bus
);

    localparam int CNT_W = $clog2(FILT_CYC + 1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYC - 1);
    localparam logic [9:0] BLANK_LAST = (BLANK_CYC > 0) ? 10'(BLANK_CYC - 1) : 10'd0;

    if (FILT_CYC < 1 || FILT_CYC > 255 || BLANK_CYC < 0 || BLANK_CYC > 1023 || UDLY < 0) begin : g_param_chk
        $error("fs_vmon_deglitch: parameter out of legal range");
    end

    typedef enum logic [1:0] {IDLE, BLANK, RUN} state_t;

    state_t           state;
    logic [9:0]       blank_cnt;
    logic             blank_active_q;
    logic             run_p0;
    logic             run_p1;
    logic             fault_any_q;

    logic [11:0]      raw;
    logic [11:0]      sync_p0;
    logic [11:0]      sync_p1;
    logic [11:0]      ch_en;
    logic [11:0]      flt;
    logic [11:0]      flt_nxt;
    logic [CNT_W-1:0] cnt     [12];
    logic [CNT_W-1:0] cnt_nxt [12];
    logic             filt_en;

    // Bit order matches the sticky status layout
    assign raw   = {bus.vmonx_uv_raw, bus.vmonx_ov_raw, bus.vddio_uv_raw, bus.vddio_ov_raw,
                    bus.vcoremon_uv_raw, bus.vcoremon_ov_raw};
    assign ch_en = {bus.vmon_en, bus.vmon_en, 4'hF};

    // Two-flop synchronizer stage; runs in every FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Filtering is released two cycles into RUN so a level already present during
    // blanking sees the same latency as one arriving at RUN entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            blank_cnt      <= '0;
            blank_active_q <= 1'b0;
            run_p0         <= 1'b0;
            run_p1         <= 1'b0;
        end else if (!bus.fs_enable) begin
            state          <= IDLE;
            blank_cnt      <= '0;
            blank_active_q <= 1'b0;
            run_p0         <= 1'b0;
            run_p1         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    blank_cnt <= '0;
                    run_p0    <= 1'b0;
                    run_p1    <= 1'b0;
                    if (BLANK_CYC == 0) begin
                        state          <= RUN;
                        blank_active_q <= 1'b0;
                    end else begin
                        state          <= BLANK;
                        blank_active_q <= 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        state          <= RUN;
                        blank_active_q <= 1'b0;
                    end else begin
                        blank_cnt <= blank_cnt + 10'd1;
                    end
                end
                RUN: begin
                    run_p0 <= 1'b1;
                    run_p1 <= run_p0;
                end
                default: begin
                    state          <= IDLE;
                    blank_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign filt_en = run_p1 & bus.fs_enable;

    always_comb begin
        flt_nxt = flt;
        cnt_nxt = cnt;
        for (int i = 0; i < 12; i++) begin
            if (!filt_en || !ch_en[i]) begin
                flt_nxt[i] = 1'b0;
                cnt_nxt[i] = '0;
            end else if (sync_p1[i] == flt[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == FILT_LAST) begin
                flt_nxt[i] = ~flt[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Debounce state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt         <= '0;
            fault_any_q <= 1'b0;
            for (int i = 0; i < 12; i++) cnt[i] <= '0;
        end else begin
            flt         <= flt_nxt;
            fault_any_q <= |flt_nxt;
            cnt         <= cnt_nxt;
        end
    end

    assign bus.vcoremon_ov    = flt[0];
    assign bus.vcoremon_uv    = flt[1];
    assign bus.vddio_ov       = flt[2];
    assign bus.vddio_uv       = flt[3];
    assign bus.vmonx_ov       = flt[7:4];
    assign bus.vmonx_uv       = flt[11:8];
    assign bus.blank_active   = blank_active_q;
    assign bus.vmon_fault_any = fault_any_q;

`ifdef FS_VMON_STICKY_EN
    logic [11:0] sticky_q;

    // Set on a filtered rising edge wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~bus.sticky_clr) | (flt_nxt & ~flt);
        end
    end

    assign bus.sticky_sts = sticky_q;
`endif

endmodule
